wb_merge: RTL and testbench



---
 rtl/wb_merge.sv | 166 ++++++++++++++++
 tb/tb_wb_merge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_merge.sv
// Writeback merge: ALU results and FIFO-buffered load returns share one register-file write port.
// Optional macro WB_MERGE_PENDING_EN adds chk_* lookup ports flagging registers with an in-flight write.
module wb_merge #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int TID_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [TID_W-1:0]         alu_tid,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [TID_W-1:0]         mem_tid,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     wena,
  output logic [ADDR_W-1:0]        waddr,
  output logic [DATA_W-1:0]        wdata,
  output logic [TID_W-1:0]         w_thread,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef WB_MERGE_PENDING_EN
  ,
  input  logic [TID_W-1:0]         chk_tid,
  input  logic [ADDR_W-1:0]        chk_addr0,
  input  logic [ADDR_W-1:0]        chk_addr1,
  output logic                     chk_hit0,
  output logic                     chk_hit1
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [TID_W-1:0]  tid_mem_q  [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wena_q, wena_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TID_W-1:0]  wthr_q, wthr_d;

  logic full_s, push_s, pop_s, alu_win_s;

  // Handshake readies come only from the registered occupancy
  always_comb begin
    full_s    = (count_q == FULL_CNT);
    alu_ready = !reset && !full_s;
    mem_ready = !reset && (count_q < FULL_CNT);
    push_s    = mem_valid && mem_ready && (mem_addr != ADDR_ZERO);
  end

  // Port arbitration and next write-stage contents
  always_comb begin
    pop_s     = 1'b0;
    alu_win_s = 1'b0;
    wena_d    = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wthr_d    = wthr_q;
    if (full_s) begin
      pop_s = 1'b1;
    end else if (alu_valid) begin
      alu_win_s = 1'b1;
    end else if (count_q != {CNT_W{1'b0}}) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end

    // An ALU write to register zero takes the port but produces no write
    if (pop_s) begin
      wena_d  = 1'b1;
      waddr_d = addr_mem_q[rd_ptr_q];
      wdata_d = data_mem_q[rd_ptr_q];
      wthr_d  = tid_mem_q[rd_ptr_q];
    end else if (alu_win_s && (alu_addr != ADDR_ZERO)) begin
      wena_d  = 1'b1;
      waddr_d = alu_addr;
      wdata_d = alu_data;
      wthr_d  = alu_tid;
    end else begin
      wena_d  = 1'b0;
    end

    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Control state and registered write-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      wena_q   <= 1'b0;
      waddr_q  <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      wthr_q   <= {TID_W{1'b0}};
    end else begin
      count_q <= count_d;
      wena_q  <= wena_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wthr_q  <= wthr_d;
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Load-return storage; no push is possible while reset is high
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_q[wr_ptr_q] <= mem_data;
      addr_mem_q[wr_ptr_q] <= mem_addr;
      tid_mem_q[wr_ptr_q]  <= mem_tid;
    end
  end

  assign wena       = wena_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign w_thread   = wthr_q;
  assign fifo_count = count_q;

`ifdef WB_MERGE_PENDING_EN
  function automatic logic tag_match(input logic [TID_W-1:0] tid_a, input logic [ADDR_W-1:0] addr_a,
                                     input logic [TID_W-1:0] tid_b, input logic [ADDR_W-1:0] addr_b);
    return (tid_a == tid_b) && (addr_a == addr_b);
  endfunction

  logic [PTR_W-1:0] off_s [DEPTH];
  logic             hit0_s, hit1_s;

  // An entry is live when its distance from the read pointer is below the count
  always_comb begin
    hit0_s = wena_q && tag_match(wthr_q, waddr_q, chk_tid, chk_addr0);
    hit1_s = wena_q && tag_match(wthr_q, waddr_q, chk_tid, chk_addr1);
    for (int i = 0; i < DEPTH; i++) begin
      off_s[i] = PTR_W'(i) - rd_ptr_q;
      if ({1'b0, off_s[i]} < count_q) begin
        hit0_s = hit0_s | tag_match(tid_mem_q[i], addr_mem_q[i], chk_tid, chk_addr0);
        hit1_s = hit1_s | tag_match(tid_mem_q[i], addr_mem_q[i], chk_tid, chk_addr1);
      end else begin
        hit0_s = hit0_s;
        hit1_s = hit1_s;
      end
    end
    chk_hit0 = hit0_s && (chk_addr0 != ADDR_ZERO);
    chk_hit1 = hit1_s && (chk_addr1 != ADDR_ZERO);
  end
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Self-checking bench for wb_merge: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_merge;
  localparam int DEPTH = 4, DATA_W = 32, ADDR_W = 4, TID_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, alu_valid, mem_valid;
  logic              alu_ready, mem_ready, wena;
  logic [TID_W-1:0]  alu_tid, mem_tid, w_thread;
  logic [ADDR_W-1:0] alu_addr, mem_addr, waddr;
  logic [DATA_W-1:0] alu_data, mem_data, wdata;
  logic [2:0]        fifo_count;
`ifdef WB_MERGE_PENDING_EN
  logic [TID_W-1:0]  chk_tid;
  logic [ADDR_W-1:0] chk_addr0, chk_addr1;
  logic              chk_hit0, chk_hit1;
`endif

  wb_merge #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TID_W(TID_W)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_tid(alu_tid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_tid(mem_tid), .mem_addr(mem_addr), .mem_data(mem_data),
    .wena(wena), .waddr(waddr), .wdata(wdata), .w_thread(w_thread), .fifo_count(fifo_count)
`ifdef WB_MERGE_PENDING_EN
    , .chk_tid(chk_tid), .chk_addr0(chk_addr0), .chk_addr1(chk_addr1), .chk_hit0(chk_hit0), .chk_hit1(chk_hit1)
`endif
  );

  typedef struct packed {
    logic [TID_W-1:0]  tid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               q[$];
  logic              m_wena = 1'b0;
  logic [ADDR_W-1:0] m_waddr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [TID_W-1:0]  m_wthr = '0;
  bit                m_show = 1'b0;
  bit                acc_a, acc_m;
  int                n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

`ifdef WB_MERGE_PENDING_EN
  function automatic bit model_hit(input logic [TID_W-1:0] t, input logic [ADDR_W-1:0] a);
    bit h = 1'b0;
    if (a == '0) return 1'b0;
    foreach (q[i]) if (q[i].tid == t && q[i].addr == a) h = 1'b1;
    if (m_wena && m_wthr == t && m_waddr == a) h = 1'b1;
    return h;
  endfunction
`endif

  // One clock: check readies, advance the model, then check the registered outputs.
  task automatic step();
    bit  rdy_a, rdy_m, pop, push;
    wr_t e;
    #1;
    rdy_a = !reset && (q.size() != DEPTH);
    rdy_m = !reset && (q.size() < DEPTH);
    check_eq("alu_ready", 64'(alu_ready), 64'(rdy_a));
    check_eq("mem_ready", 64'(mem_ready), 64'(rdy_m));
`ifdef WB_MERGE_PENDING_EN
    check_eq("chk_hit0", 64'(chk_hit0), 64'(model_hit(chk_tid, chk_addr0)));
    check_eq("chk_hit1", 64'(chk_hit1), 64'(model_hit(chk_tid, chk_addr1)));
`endif
    acc_a = alu_valid && rdy_a;
    acc_m = mem_valid && rdy_m;
    if (reset) begin
      q.delete();
      m_wena = 1'b0; m_waddr = '0; m_wdata = '0; m_wthr = '0;
      m_show = 1'b1;
    end else begin
      m_show = 1'b0;
      pop  = (q.size() == DEPTH) || (!alu_valid && q.size() > 0);
      push = acc_m && (mem_addr != '0);
      if (pop) begin
        e = q.pop_front();
        m_wena = 1'b1; m_waddr = e.addr; m_wdata = e.data; m_wthr = e.tid;
      end else if (alu_valid && alu_addr != '0) begin
        m_wena = 1'b1; m_waddr = alu_addr; m_wdata = alu_data; m_wthr = alu_tid;
      end else begin
        m_wena = 1'b0;
      end
      if (push) begin
        e.tid = mem_tid; e.addr = mem_addr; e.data = mem_data;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_eq("wena", 64'(wena), 64'(m_wena));
    check_eq("fifo_count", 64'(fifo_count), 64'(q.size()));
    if (m_wena || m_show) begin
      check_eq("waddr", 64'(waddr), 64'(m_waddr));
      check_eq("wdata", 64'(wdata), 64'(m_wdata));
      check_eq("w_thread", 64'(w_thread), 64'(m_wthr));
    end
  endtask

  task automatic set_alu(input bit v, input int t, input int a, input logic [31:0] d);
    alu_valid = v; alu_tid = TID_W'(t); alu_addr = ADDR_W'(a); alu_data = d;
  endtask

  task automatic set_mem(input bit v, input int t, input int a, input logic [31:0] d);
    mem_valid = v; mem_tid = TID_W'(t); mem_addr = ADDR_W'(a); mem_data = d;
  endtask

  initial begin
    reset = 1'b1;
    set_alu(1'b0, 0, 0, 32'h0);
    set_mem(1'b0, 0, 0, 32'h0);
`ifdef WB_MERGE_PENDING_EN
    chk_tid = '0; chk_addr0 = '0; chk_addr1 = '0;
`endif
    step(); step();
    check_eq("reset_count", 64'(fifo_count), 64'd0);
    reset = 1'b0;

    // ALU only
    set_alu(1'b1, 2, 5, 32'hDEADBEEF);
    step();
    check_eq("alu_only_wdata", 64'(wdata), 64'hDEADBEEF);
    check_eq("alu_only_thr", 64'(w_thread), 64'd2);
    set_alu(1'b0, 0, 0, 32'h0);
    step();

    // Loads only, in order
    set_mem(1'b1, 1, 3, 32'h11); step();
    set_mem(1'b1, 1, 3, 32'h22); step();
    check_eq("load_order0", 64'(wdata), 64'h11);
    set_mem(1'b1, 0, 7, 32'h33); step();
    check_eq("load_order1", 64'(wdata), 64'h22);
    set_mem(1'b0, 0, 0, 32'h0); step();
    check_eq("load_order2", 64'(wdata), 64'h33);
    check_eq("load_drained", 64'(fifo_count), 64'd0);
    step();

    // Contention: ALU held high while the FIFO fills
    set_alu(1'b1, 0, 1, 32'hA0A0A0A0);
    for (int i = 0; i < 4; i++) begin
      set_mem(1'b1, 1, 8 + i, 32'h100 + 32'(i));
      step();
    end
    check_eq("cont_full", 64'(fifo_count), 64'd4);
    check_eq("cont_mem_rdy", 64'(mem_ready), 64'd0);
    check_eq("cont_alu_rdy", 64'(alu_ready), 64'd0);
    set_mem(1'b0, 0, 0, 32'h0);
    step();
    check_eq("cont_pop_data", 64'(wdata), 64'h100);
    check_eq("cont_after", 64'(fifo_count), 64'd3);
    check_eq("cont_alu_rdy2", 64'(alu_ready), 64'd1);
    set_alu(1'b0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) step();

    // Register zero on both sources
    set_alu(1'b1, 1, 0, 32'h55); step();
    check_eq("alu_r0_wena", 64'(wena), 64'd0);
    set_alu(1'b0, 0, 0, 32'h0);
    set_mem(1'b1, 2, 0, 32'h66); step();
    check_eq("mem_r0_count", 64'(fifo_count), 64'd0);
    set_mem(1'b0, 0, 0, 32'h0);

`ifdef WB_MERGE_PENDING_EN
    // Pending lookup of a buffered load
    set_alu(1'b1, 0, 2, 32'h1);
    set_mem(1'b1, 3, 9, 32'h99); step();
    set_mem(1'b0, 0, 0, 32'h0);
    chk_tid = 2'd3; chk_addr0 = 4'd9; chk_addr1 = 4'd0;
    #1;
    check_eq("pend_hit0", 64'(chk_hit0), 64'd1);
    check_eq("pend_hit1", 64'(chk_hit1), 64'd0);
    set_alu(1'b0, 0, 0, 32'h0);
    step(); step(); step();
    check_eq("pend_drained", 64'(chk_hit0), 64'd0);
`endif

    // Reset mid-stream with three buffered loads
    set_alu(1'b1, 0, 4, 32'h4444);
    for (int i = 0; i < 3; i++) begin
      set_mem(1'b1, 2, 10 + i, 32'h200 + 32'(i));
      step();
    end
    check_eq("rst_pre_count", 64'(fifo_count), 64'd3);
    set_alu(1'b0, 0, 0, 32'h0);
    set_mem(1'b0, 0, 0, 32'h0);
    reset = 1'b1; step(); reset = 1'b0;
    check_eq("rst_count", 64'(fifo_count), 64'd0);
    check_eq("rst_wena", 64'(wena), 64'd0);
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic; payloads stay stable until accepted
    acc_a = 1'b1; acc_m = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!alu_valid || acc_a)
        set_alu($urandom_range(0, 99) < ((c % 512) < 256 ? 60 : 25), int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15)), $urandom);
      if (!mem_valid || acc_m)
        set_mem($urandom_range(0, 99) < ((c % 512) < 256 ? 70 : 30), int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15)), $urandom);
`ifdef WB_MERGE_PENDING_EN
      chk_tid = TID_W'($urandom); chk_addr0 = ADDR_W'($urandom); chk_addr1 = ADDR_W'($urandom);
`endif
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
